// File: rtl/misao_pkg.sv
// misao_core shared definitions: opcodes, link modes, FSM states.
// Helpers map the CFG link field onto a mode and an immediate count.
package misao_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_SS   = 4'h2;
   localparam logic [3:0] OP_RSS  = 4'h3;
   localparam logic [3:0] OP_RACC = 4'h4;
   localparam logic [3:0] OP_XOP  = 4'hF;

   localparam logic [3:0] XOP_CFG = 4'h1;
   localparam logic [3:0] XOP_SA  = 4'h2;
   localparam logic [3:0] XOP_RSA = 4'h3;
   localparam logic [3:0] XOP_RRS = 4'h4;

   typedef enum logic [1:0] {
      UL   = 2'd0,
      LK8  = 2'd1,
      LK16 = 2'd2
   } link_t;

   typedef enum logic [1:0] {
      S_DECODE = 2'd0,
      S_EXT    = 2'd1,
      S_IMM    = 2'd2,
      S_CFGIMM = 2'd3
   } state_t;

   // Mode 11 is folded onto LK16.
   function automatic link_t cfg_link(input logic [1:0] m);
      link_t l;
      case (m)
         2'b00:   l = UL;
         2'b01:   l = LK8;
         default: l = LK16;
      endcase
      return l;
   endfunction

   // Immediate nibbles remaining after the first one.
   function automatic logic [1:0] link_cnt(input link_t l);
      logic [1:0] c;
      case (l)
         UL:      c = 2'd0;
         LK8:     c = 2'd1;
         default: c = 2'd3;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/misao_lnk.sv
// Link-width datapath helper: rotates, masked slice swap and
// nibble insertion for the immediate load.
module misao_lnk
   import misao_pkg::*;
(
   input  logic [1:0]  lnk,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [3:0]  nib,
   input  logic [1:0]  idx,
   output logic [15:0] rot_a,
   output logic [15:0] rot_b,
   output logic [15:0] swp_a,
   output logic [15:0] swp_b,
   output logic [15:0] ins_a
);

   logic [15:0] mask;

   always_comb begin
      mask  = 16'hFFFF;
      rot_a = a;
      rot_b = b;
      case (lnk)
         UL: begin
            mask  = 16'h000F;
            rot_a = {a[3:0], a[15:4]};
            rot_b = {b[3:0], b[15:4]};
         end
         LK8: begin
            mask  = 16'h00FF;
            rot_a = {a[7:0], a[15:8]};
            rot_b = {b[7:0], b[15:8]};
         end
         default: ;
      endcase
      swp_a = (a & ~mask) | (b & mask);
      swp_b = (b & ~mask) | (a & mask);
      ins_a = a;
      ins_a[{idx, 2'b00} +: 4] = nib;
   end

endmodule

// File: rtl/misao_core.sv
// Nibble-serial 16-bit accumulator core, register-management subset.
// One instruction nibble is consumed per clock, low nibble first.
module misao_core
   import misao_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output logic        mem_enable_read,
   output logic        mem_enable_write,
   input  logic [7:0]  mem_data_in,
   output logic [14:0] mem_addr,
   output logic        mem_rw,
   output logic [7:0]  mem_data_out,
   output logic [15:0] test_data,
   output logic        test_carry
);

   logic [15:0] pc;
   logic [15:0] acc, rs0, rs1, ra0, ra1;
   logic [7:0]  cfg;
   logic [3:0]  cfg_lo;
   logic        carry;

   state_t      state, state_n;
   logic [1:0]  cnt, cnt_n;
   logic [1:0]  idx, idx_n;
   link_t       lnk_r, lnk_n;
   link_t       cur_lnk, lnk_use;

   logic [3:0]  nib;
   logic        do_ldi, do_ss, do_rss, do_racc;
   logic        do_sa, do_rsa, do_rrs;
   logic        do_cfg_lo, do_cfg_hi;

   logic [15:0] rot_a, rot_b, swp_a, swp_b, ins_a;
   logic        unused_cfg;

   assign nib     = pc[0] ? mem_data_in[7:4] : mem_data_in[3:0];
   assign cur_lnk = cfg_link(cfg[1:0]);
   // Decode-time ops see the live CFG; later stages use the latched mode.
   assign lnk_use = (state == S_DECODE) ? cur_lnk : lnk_r;
   assign unused_cfg = ^cfg[7:2];

   misao_lnk u_lnk (
      .lnk   (lnk_use),
      .a     (acc),
      .b     (rs0),
      .nib   (nib),
      .idx   (idx),
      .rot_a (rot_a),
      .rot_b (rot_b),
      .swp_a (swp_a),
      .swp_b (swp_b),
      .ins_a (ins_a)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_DECODE;
         cnt   <= 2'd0;
         idx   <= 2'd0;
         lnk_r <= UL;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         lnk_r <= lnk_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      idx_n     = idx;
      lnk_n     = lnk_r;
      do_ldi    = 1'b0;
      do_ss     = 1'b0;
      do_rss    = 1'b0;
      do_racc   = 1'b0;
      do_sa     = 1'b0;
      do_rsa    = 1'b0;
      do_rrs    = 1'b0;
      do_cfg_lo = 1'b0;
      do_cfg_hi = 1'b0;
      unique case (state)
         S_DECODE: begin
            lnk_n = cur_lnk;
            case (nib)
               OP_LDI: begin
                  state_n = S_IMM;
                  cnt_n   = link_cnt(cur_lnk);
                  idx_n   = 2'd0;
               end
               OP_SS:   do_ss   = 1'b1;
               OP_RSS:  do_rss  = 1'b1;
               OP_RACC: do_racc = 1'b1;
               OP_XOP:  state_n = S_EXT;
               default: ;
            endcase
         end
         S_EXT: begin
            state_n = S_DECODE;
            case (nib)
               XOP_CFG: begin
                  state_n = S_CFGIMM;
                  cnt_n   = 2'd1;
               end
               XOP_SA:  do_sa  = 1'b1;
               XOP_RSA: do_rsa = 1'b1;
               XOP_RRS: do_rrs = 1'b1;
               default: ;
            endcase
         end
         S_IMM: begin
            do_ldi = 1'b1;
            idx_n  = idx + 2'd1;
            cnt_n  = cnt - 2'd1;
            if (cnt == 2'd0) state_n = S_DECODE;
         end
         S_CFGIMM: begin
            if (cnt != 2'd0) begin
               do_cfg_lo = 1'b1;
               cnt_n     = 2'd0;
            end else begin
               do_cfg_hi = 1'b1;
               state_n   = S_DECODE;
            end
         end
         default: state_n = S_DECODE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc     <= 16'h0000;
         acc    <= 16'h0000;
         rs0    <= 16'h0000;
         rs1    <= 16'h0000;
         ra0    <= 16'h0000;
         ra1    <= 16'h0000;
         cfg    <= 8'h00;
         cfg_lo <= 4'h0;
         carry  <= 1'b0;
      end else begin
         pc    <= pc + 16'd1;
         carry <= carry;
         if (do_ldi) acc <= ins_a;
         if (do_ss) begin
            acc <= swp_a;
            rs0 <= swp_b;
         end
         if (do_rss) begin
            rs0 <= rs1;
            rs1 <= rs0;
         end
         if (do_racc) acc <= rot_a;
         if (do_rrs)  rs0 <= rot_b;
         if (do_sa) begin
            acc <= ra0;
            ra0 <= acc;
         end
         if (do_rsa) begin
            ra0 <= ra1;
            ra1 <= ra0;
         end
         if (do_cfg_lo) cfg_lo <= nib;
         if (do_cfg_hi) cfg    <= {nib, cfg_lo};
      end
   end

   assign mem_enable_read  = ~rst;
   assign mem_enable_write = 1'b0;
   assign mem_rw           = 1'b1;
   assign mem_data_out     = 8'h00;
   assign mem_addr         = pc[15:1];
   assign test_data        = acc;
   assign test_carry       = carry;

endmodule

// File: tb/tb_misao_core.sv
// misao_core bench: directed + random nibble programs checked each
// cycle against an instruction-level interpreter.
module tb_misao_core;

   logic        clk;
   logic        rst;
   logic        mem_enable_read;
   logic        mem_enable_write;
   logic [7:0]  mem_data_in;
   logic [14:0] mem_addr;
   logic        mem_rw;
   logic [7:0]  mem_data_out;
   logic [15:0] test_data;
   logic        test_carry;

   logic [7:0]  mem [0:32767];
   logic [15:0] exp_q [$];
   int          pin_i [$];
   logic [15:0] pin_v [$];
   int          np;
   int          checks;
   int          errors;

   misao_core dut (
      .clk              (clk),
      .rst              (rst),
      .mem_enable_read  (mem_enable_read),
      .mem_enable_write (mem_enable_write),
      .mem_data_in      (mem_data_in),
      .mem_addr         (mem_addr),
      .mem_rw           (mem_rw),
      .mem_data_out     (mem_data_out),
      .test_data        (test_data),
      .test_carry       (test_carry)
   );

   assign mem_data_in = mem[mem_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] nib_at(input int p);
      logic [7:0] b;
      b = mem[(p >> 1) & 32'h7FFF];
      return ((p & 1) != 0) ? b[7:4] : b[3:0];
   endfunction

   function automatic logic [15:0] rotn(input logic [15:0] v, input int k);
      int x;
      if (k == 0) return v;
      x = (int'(v) >> (4 * k)) | (int'(v) << (16 - 4 * k));
      return 16'(x & 32'hFFFF);
   endfunction

   // Instruction-level interpreter: ACC after every consumed nibble.
   task automatic build_model(input int n);
      int p, w, k;
      logic [15:0] a, s0, s1, r0, r1, t, m;
      logic [7:0]  cf;
      logic [3:0]  op, x, lo;
      exp_q.delete();
      p = 0; a = 0; s0 = 0; s1 = 0; r0 = 0; r1 = 0; cf = 0;
      while (exp_q.size() < n) begin
         w = (cf[1:0] == 2'b00) ? 1 : (cf[1:0] == 2'b01) ? 2 : 4;
         k = (w == 4) ? 0 : w;
         m = (w == 4) ? 16'hFFFF : 16'(((1 << (4 * w)) - 1));
         op = nib_at(p); p++;
         case (op)
            4'h1: begin
               exp_q.push_back(a);
               for (int i = 0; i < w; i++) begin
                  x = nib_at(p); p++;
                  a = 16'((int'(a) & ~(15 << (4 * i))) | (int'(x) << (4 * i)));
                  exp_q.push_back(a);
               end
            end
            4'h2: begin
               t = (a & ~m) | (s0 & m);
               s0 = (s0 & ~m) | (a & m);
               a = t;
               exp_q.push_back(a);
            end
            4'h3: begin
               t = s0; s0 = s1; s1 = t;
               exp_q.push_back(a);
            end
            4'h4: begin
               a = rotn(a, k);
               exp_q.push_back(a);
            end
            4'hF: begin
               exp_q.push_back(a);
               x = nib_at(p); p++;
               case (x)
                  4'h1: begin
                     exp_q.push_back(a);
                     lo = nib_at(p); p++;
                     exp_q.push_back(a);
                     x = nib_at(p); p++;
                     cf = {x, lo};
                     exp_q.push_back(a);
                  end
                  4'h2: begin t = a; a = r0; r0 = t; exp_q.push_back(a); end
                  4'h3: begin t = r0; r0 = r1; r1 = t; exp_q.push_back(a); end
                  4'h4: begin s0 = rotn(s0, k); exp_q.push_back(a); end
                  default: exp_q.push_back(a);
               endcase
            end
            default: exp_q.push_back(a);
         endcase
      end
   endtask

   task automatic put(input logic [3:0] v);
      if ((np & 1) != 0) mem[np >> 1][7:4] = v;
      else mem[np >> 1][3:0] = v;
      np++;
   endtask

   task automatic ldi(input int w, input logic [15:0] v);
      put(4'h1);
      for (int i = 0; i < w; i++) put(v[4 * i +: 4]);
   endtask

   task automatic cfgw(input logic [7:0] c);
      put(4'hF); put(4'h1); put(c[3:0]); put(c[7:4]);
   endtask

   task automatic xop(input logic [3:0] x);
      put(4'hF); put(x);
   endtask

   task automatic pin(input logic [15:0] v);
      pin_i.push_back(np - 1);
      pin_v.push_back(v);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
      np = 0;
      pin_i.delete();
      pin_v.delete();
   endtask

   task automatic check_pins();
      for (int k = 0; k < pin_i.size(); k++) begin
         checks++;
         if (exp_q[pin_i[k]] !== pin_v[k]) begin
            errors++;
            $display("FAIL model_pin%0d cyc=%0d got %h want %h",
                     k, pin_i[k], exp_q[pin_i[k]], pin_v[k]);
         end
      end
   endtask

   task automatic check_reset(input string tag);
      checks++;
      if (test_data !== 16'h0 || mem_addr !== 15'h0 ||
          mem_enable_read !== 1'b0 || test_carry !== 1'b0) begin
         errors++;
         $display("FAIL %s acc=%h addr=%h rd=%b c=%b want 0/0/0/0",
                  tag, test_data, mem_addr, mem_enable_read, test_carry);
      end
   endtask

   // Release reset and compare DUT against the model for n cycles.
   task automatic run(input int n);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checks++;
         if (test_data !== exp_q[i]) begin
            errors++;
            $display("FAIL acc cyc=%0d got %h want %h", i, test_data, exp_q[i]);
         end
         checks++;
         if (test_carry !== 1'b0) begin
            errors++;
            $display("FAIL carry cyc=%0d got %b want 0", i, test_carry);
         end
         checks++;
         if (mem_addr !== 15'((i + 1) >> 1)) begin
            errors++;
            $display("FAIL addr cyc=%0d got %h want %h", i, mem_addr, 15'((i + 1) >> 1));
         end
         checks++;
         if (mem_enable_read !== 1'b1 || mem_enable_write !== 1'b0 ||
             mem_rw !== 1'b1 || mem_data_out !== 8'h00) begin
            errors++;
            $display("FAIL strobes cyc=%0d rd=%b wr=%b rw=%b do=%h want 1/0/1/00",
                     i, mem_enable_read, mem_enable_write, mem_rw, mem_data_out);
         end
      end
      rst = 1'b1;
   endtask

   initial begin
      int r;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      clear_mem();

      // Directed program followed by random nibbles.
      ldi(1, 16'h0005);        pin(16'h0005);
      cfgw(8'h4D); ldi(2, 16'h00B3);   pin(16'h00B3);
      cfgw(8'h4E); ldi(4, 16'hCAFE);   pin(16'hCAFE);
      cfgw(8'h4D);
      if ((np & 1) == 0) put(4'h0);
      ldi(2, 16'h0091);        pin(16'hCA91);
      cfgw(8'h4C); ldi(1, 16'h0006);   pin(16'hCA96);
      cfgw(8'h4E); ldi(4, 16'h1357); put(4'h2); pin(16'h0000);
      cfgw(8'h4C); xop(4'h4);
      cfgw(8'h4E); put(4'h2);  pin(16'h7135);
      cfgw(8'h4C); ldi(1, 16'h000A); put(4'h4); pin(16'hA713);
      cfgw(8'h4D); put(4'h4);  pin(16'h13A7);
      cfgw(8'h4E); put(4'h4);  pin(16'h13A7);
      xop(4'h4);
      xop(4'h2);               pin(16'h0000);
      xop(4'h3); xop(4'h2); xop(4'h3); xop(4'h2); pin(16'h13A7);
      ldi(4, 16'hD271); put(4'h2); pin(16'h0000);
      ldi(4, 16'h89A7); cfgw(8'h4C); put(4'h2); pin(16'h89A1);
      put(4'h3);
      cfgw(8'h4D); put(4'h2);  pin(16'h8900);
      cfgw(8'h4E); put(4'h3); put(4'h2); pin(16'hD277);
      while (np < 3000) begin
         r = $urandom_range(0, 9);
         if (r <= 4) put(4'(r));
         else if (r == 5) put(4'hF);
         else put(4'($urandom_range(0, 15)));
      end
      build_model(3000);
      check_pins();

      repeat (2) @(negedge clk);
      check_reset("reset_state");
      run(3000);

      // LK16 load interrupted by reset after two immediate nibbles.
      @(negedge clk);
      clear_mem();
      cfgw(8'h4E); ldi(4, 16'h4321);
      pin_i.push_back(6);
      pin_v.push_back(16'h0021);
      build_model(7);
      check_pins();
      run(7);
      @(negedge clk);
      check_reset("mid_ldi_reset");

      clear_mem();
      ldi(1, 16'h0005); pin(16'h0005);
      build_model(4);
      check_pins();
      run(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/misao_core.md
# misao_core

Nibble-serial 16-bit accumulator CPU core (MISA-O ISA, register-management subset). It fetches bytes from an external byte-wide memory and executes one 4-bit instruction nibble per clock, low nibble first. It implements immediate loads, link-width configuration, rotates and register-bank swaps. It sits at the top of the processor, with architectural state exposed on test ports for verification.

## Interface
- No parameters.
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- mem_enable_read  out  1  byte read strobe; 1 every non-reset cycle
- mem_enable_write  out  1  write strobe; constant 0 in this subset
- mem_data_in  in  8  read data, combinational (same-cycle) with mem_addr
- mem_addr  out  15  byte address = PC[15:1]
- mem_rw  out  1  1 = read, 0 = write; constant 1
- mem_data_out  out  8  write data; constant 0
- test_data  out  16  ACC
- test_carry  out  1  carry flag

## Operation
- State:
  - PC: 16-bit nibble address.
  - ACC, RS0, RS1, RA0, RA1: 16 bits each.
  - CFG: 8 bits. CFG[1:0] is the link mode: 00 UL (4-bit), 01 LK8, 10 LK16, 11 treated as LK16. CFG[7:2] is stored but has no effect.
  - Carry flag, 1 bit.
- Current nibble: mem_data_in[3:0] when PC[0]=0, else [7:4]. PC increments by 1 every cycle and wraps at 0xFFFF.
- Primary opcodes:
  - 0x0 NOP.
  - 0x1 LDI: loads the immediate into the low link-width bits of ACC; upper bits are preserved.
    - Immediate is 1/2/4 nibbles for UL/LK8/LK16, least-significant nibble first.
    - Immediate nibble i is written to ACC[4i+3:4i].
  - 0x2 SS: swaps the low link-width slice of ACC with the same slice of RS0. Upper bits of both are preserved. LK16 is a full swap.
  - 0x3 RSS: full swap of RS0 and RS1.
  - 0x4 RACC: rotates ACC right by 4 (UL) or by 8 (LK8). No-op in LK16.
  - 0xF XOP: the next nibble is an extended opcode.
  - 0x5–0xE: reserved, execute as NOP.
- Extended opcodes (after XOP):
  - 0x1 CFG: the next 2 nibbles (low first) are written to CFG. The write takes effect when the last nibble is consumed.
  - 0x2 SA: full 16-bit swap of ACC and RA0, in every link mode.
  - 0x3 RSA: full swap of RA0 and RA1.
  - 0x4 RRS: rotates RS0 exactly as RACC rotates ACC.
  - Others: NOP.
- Link mode is sampled at instruction decode.
- The carry flag is not modified by any implemented instruction.
- FSM states:
  - DECODE: XOP→EXT, LDI→IMM (count = width−1 after the first immediate), all others execute in place.
  - EXT: CFG→CFGIMM; SA, RSA, RRS execute; then →DECODE.
  - IMM: write nibble; when the count reaches 0 →DECODE.
  - CFGIMM: 2 nibbles, then →DECODE.
- Instructions and immediates may straddle byte boundaries; alignment is irrelevant.

## Timing
- One nibble per cycle. Architectural updates occur on the rising edge that ends the consuming cycle.
- Latency: NOP/SS/RSS/RACC 1 cycle; SA/RSA/RRS 2; CFG 4; LDI 2/3/5 (UL/LK8/LK16).
- Reset values: PC=0, ACC=RS0=RS1=RA0=RA1=0, CFG=0x00 (UL), carry=0, FSM=DECODE.
- While rst=1: mem_enable_read=0; all other outputs hold their reset values.
- Reset asserted mid-instruction discards any partial LDI/CFG/XOP. Nibbles of a partial LDI already written to ACC are cleared by reset.
- After reset: the first fetch is byte 0, low nibble, on the first cycle with rst=0.
- mem_addr changes only on clock edges; no handshake or wait states.

## Structure
- misao_pkg holds:
  - Primary and extended opcode localparams.
  - Link-mode enum {UL, LK8, LK16}.
  - FSM state enum.
- Sub-module misao_lnk: a combinational link-width helper providing the rotate (by 4/8/none) and masked-slice swap used by RACC/RRS/SS/LDI.

## Test plan
- Reset, byte1={5,LDI} → ACC=0x0005. Then CFG 0x4D, then LDI 0xB3 → ACC=0x00B3. Then CFG 0x4E, then LDI 0xCAFE → ACC=0xCAFE.
- LK8, ACC=0xCAFE: LDI starting at a high nibble with imm 0x91 → ACC=0xCA91. Then CFG 0x4C, LDI 6 → ACC=0xCA96 (upper bits preserved).
- RS0 rotation:
  - UL: RS0=0x1357, RRS → RS0=0x7135.
  - UL: ACC=0x000A, RACC → 0xA000.
  - LK8: ACC=0x71D2, RACC → 0xD271.
  - LK16: RACC and RRS leave ACC/RS0 unchanged.
- Swaps:
  - UL: ACC=0x89A7, RS0=0xD271, SS → ACC=0x89A1, RS0=0xD277. RSS with RS1=0 → RS0=0, RS1=0xD277.
  - LK8: ACC=0x89B6, SS → ACC=0x8900, RS0=0x00B6.
  - LK16: ACC=0x2244, RS0=0xD277, SS → ACC=0xD277, RS0=0x2244.
- UL: ACC=0xD27C, SA → ACC=0, RA0=0xD27C. RSA → RA0=0, RA1=0xD27C.
- Carry stays 0 throughout. Assert rst during a LK16 LDI → ACC=0, PC=0, link=UL.
